ram_avalon_wait: RTL and testbench

RAM_AVALON_WAIT -- requirements
Module: ram_avalon_wait

---
 rtl/ram_avalon_pkg.sv | 12 +
 rtl/wait_lfsr.sv | 25 ++
 rtl/ram_avalon_wait.sv | 148 ++++++++++++++
 tb/tb_ram_avalon_wait.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ram_avalon_pkg.sv
// Shared types and constants for the wait-state Avalon RAM model.
package ram_avalon_pkg;

   localparam int WAIT_FIXED  = 0;
   localparam int WAIT_RANDOM = 1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_STALL = 1'b1
   } state_t;

endpackage

// File: rtl/wait_lfsr.sv
// 16-bit Fibonacci LFSR (x^16 + x^14 + x^13 + x^11 + 1), advances every cycle.
module wait_lfsr #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] lfsr
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   // Right-shifting form: the feedback enters at the MSB.
   always_comb begin
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
   end

   always_ff @(posedge clk) begin
      if (reset) lfsr_q <= SEED;
      else       lfsr_q <= lfsr_d;
   end

   assign lfsr = lfsr_q;

endmodule

// File: rtl/ram_avalon_wait.sv
// Byte-addressed Avalon-MM slave RAM with fixed or pseudo-random wait states,
// fault detection and completed-transfer counters.
module ram_avalon_wait
   import ram_avalon_pkg::*;
#(
   parameter string       RAM_FILE    = "",
   parameter int          ADDR_BITS   = 13,
   parameter int          WAIT_MODE   = 0,
   parameter int          WAIT_CYCLES = 0,
   parameter int          WAIT_MAX    = 3,
   parameter logic [15:0] SEED        = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic        waitrequest,
   output logic [31:0] readdata,
   output logic        error,
   output logic [31:0] rd_count,
   output logic [31:0] wr_count
);

   localparam int MEM_BYTES = 2 ** ADDR_BITS;

   logic [7:0] mem [MEM_BYTES];

   // Power-up image; memory is deliberately left out of reset.
   initial begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
   end

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        error_q, error_d;
   logic [31:0] rd_count_q, rd_count_d;
   logic [31:0] wr_count_q, wr_count_d;

   logic                 req;
   logic                 complete;
   logic                 addr_bad;
   logic                 faulty;
   logic [32:0]          end_addr;
   logic [ADDR_BITS-1:0] idx;
   logic [15:0]          lfsr_val;
   logic [15:0]          wait_w;

   wait_lfsr #(.SEED(SEED)) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .lfsr  (lfsr_val)
   );

   assign req      = read | write;
   assign idx      = address[ADDR_BITS-1:0];
   // 33-bit sum so addresses near 2**32 cannot wrap back into range.
   assign end_addr = {1'b0, address} + 33'd3;
   assign addr_bad = (address[1:0] != 2'b00) || (end_addr >= (33'd1 << ADDR_BITS));
   assign faulty   = addr_bad || (read && write);

   always_comb begin
      if (WAIT_MODE == WAIT_RANDOM) wait_w = lfsr_val % 16'(WAIT_MAX + 1);
      else                          wait_w = 16'(WAIT_CYCLES);
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      waitrequest = 1'b0;
      complete    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               if (wait_w == 16'd0) begin
                  complete = 1'b1;
               end else begin
                  waitrequest = 1'b1;
                  state_d     = ST_STALL;
                  cnt_d       = wait_w - 16'd1;
               end
            end
         end
         ST_STALL: begin
            // A master that withdraws mid-stall simply abandons the transfer.
            if (!req) begin
               state_d = ST_IDLE;
            end else if (cnt_q == 16'd0) begin
               complete = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               waitrequest = 1'b1;
               cnt_d       = cnt_q - 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (reset) begin
         waitrequest = req;
         complete    = 1'b0;
      end
   end

   always_comb begin
      error_d    = complete && faulty;
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
      if (complete && !faulty && read)  rd_count_d = rd_count_q + 32'd1;
      if (complete && !faulty && write) wr_count_d = wr_count_q + 32'd1;
   end

   always_comb begin
      readdata = 32'h0;
      if (read && !faulty)
         readdata = {mem[idx + ADDR_BITS'(3)], mem[idx + ADDR_BITS'(2)],
                     mem[idx + ADDR_BITS'(1)], mem[idx]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 16'd0;
         error_q    <= 1'b0;
         rd_count_q <= 32'd0;
         wr_count_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         error_q    <= error_d;
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (complete && write && !faulty) begin
         for (int b = 0; b < 4; b++)
            if (byteenable[b]) mem[idx + ADDR_BITS'(b)] <= writedata[8*b +: 8];
      end
   end

   assign error    = error_q;
   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;

endmodule

// File: tb/tb_ram_avalon_wait.sv
// Directed bench: zero-wait, fixed 3-wait and random-wait RAM instances.
module tb_ram_avalon_wait;

   localparam int N = 3;
   localparam int NRD = 1000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst   [N];
   logic        rd    [N];
   logic        wr    [N];
   logic [31:0] addr  [N];
   logic [31:0] wdata [N];
   logic [3:0]  be    [N];
   logic        wreq  [N];
   logic [31:0] rdata [N];
   logic        err   [N];
   logic [31:0] rdc   [N];
   logic [31:0] wrc   [N];

   int checks = 0;
   int errors = 0;
   int timeouts = 0;
   int seq_a [NRD];
   int seq_b [NRD];

   ram_avalon_wait #(.WAIT_MODE(0), .WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .reset(rst[0]), .address(addr[0]), .read(rd[0]), .write(wr[0]),
      .writedata(wdata[0]), .byteenable(be[0]), .waitrequest(wreq[0]),
      .readdata(rdata[0]), .error(err[0]), .rd_count(rdc[0]), .wr_count(wrc[0]));

   ram_avalon_wait #(.WAIT_MODE(0), .WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .reset(rst[1]), .address(addr[1]), .read(rd[1]), .write(wr[1]),
      .writedata(wdata[1]), .byteenable(be[1]), .waitrequest(wreq[1]),
      .readdata(rdata[1]), .error(err[1]), .rd_count(rdc[1]), .wr_count(wrc[1]));

   ram_avalon_wait #(.WAIT_MODE(1), .WAIT_MAX(3), .SEED(16'hACE1)) u_rnd (
      .clk(clk), .reset(rst[2]), .address(addr[2]), .read(rd[2]), .write(wr[2]),
      .writedata(wdata[2]), .byteenable(be[2]), .waitrequest(wreq[2]),
      .readdata(rdata[2]), .error(err[2]), .rd_count(rdc[2]), .wr_count(wrc[2]));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Drives one transfer and holds it until waitrequest drops; returns the
   // number of stall cycles, readdata seen on the completion cycle and the
   // error flag one cycle after completion.
   task automatic xfer(input int d, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] b,
                       output int stalls, output logic [31:0] rdv, output logic errv);
      @(negedge clk);
      rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
      #1;
      stalls = 0;
      while (wreq[d] && stalls < 32) begin
         stalls++;
         @(posedge clk); #1;
      end
      if (stalls >= 32) timeouts++;
      rdv = rdata[d];
      @(posedge clk); #1;
      rd[d] = 1'b0; wr[d] = 1'b0;
      errv = err[d];
   endtask

   task automatic do_reset(input int d);
      @(negedge clk); rst[d] = 1'b1;
      @(negedge clk); rst[d] = 1'b0;
   endtask

   task automatic run_rand(input int pass);
      int s; logic [31:0] rv; logic e;
      do_reset(2);
      for (int i = 0; i < NRD; i++) begin
         xfer(2, 1'b1, 1'b0, 32'(4 * (i % 16)), 32'h0, 4'h0, s, rv, e);
         if (pass == 0) seq_a[i] = s;
         else           seq_b[i] = s;
      end
   endtask

   initial begin
      int s; logic [31:0] rv; logic e;
      int mx, mism;
      int hist [4];
      for (int i = 0; i < N; i++) begin
         rst[i] = 1'b1; rd[i] = 1'b0; wr[i] = 1'b0;
         addr[i] = 32'h0; wdata[i] = 32'h0; be[i] = 4'h0;
      end
      repeat (2) @(negedge clk);
      chk("rst_wreq_idle", 32'(wreq[0]), 32'h0);
      chk("rst_err",       32'(err[0]),  32'h0);
      chk("rst_rd_count",  rdc[0], 32'h0);
      chk("rst_wr_count",  wrc[0], 32'h0);
      rd[0] = 1'b1; #1;
      chk("rst_wreq_req",  32'(wreq[0]), 32'h1);
      rd[0] = 1'b0;
      @(negedge clk);
      for (int i = 0; i < N; i++) rst[i] = 1'b0;

      // Zero-wait instance: basic write/read, byte lanes, faults.
      xfer(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, s, rv, e);
      chk("w0_wr_stall", 32'(s), 32'd0);
      chk("w0_wr_err", 32'(e), 32'h0);
      xfer(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, s, rv, e);
      chk("w0_rd_stall", 32'(s), 32'd0);
      chk("w0_rd_data", rv, 32'hDEADBEEF);
      chk("w0_wr_count", wrc[0], 32'd1);
      chk("w0_rd_count", rdc[0], 32'd1);
      xfer(0, 1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0101, s, rv, e);
      xfer(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, s, rv, e);
      chk("w0_be_data", rv, 32'hDE22BE44);
      xfer(0, 1'b1, 1'b0, 32'h13, 32'h0, 4'h0, s, rv, e);
      chk("w0_misalign_data", rv, 32'h0);
      chk("w0_misalign_err", 32'(e), 32'h1);
      @(posedge clk); #1;
      chk("w0_err_one_cycle", 32'(err[0]), 32'h0);
      xfer(0, 1'b0, 1'b1, 32'h2000, 32'hFFFFFFFF, 4'hF, s, rv, e);
      chk("w0_oob_err", 32'(e), 32'h1);
      xfer(0, 1'b1, 1'b1, 32'h10, 32'h0, 4'hF, s, rv, e);
      chk("w0_rdwr_data", rv, 32'h0);
      chk("w0_rdwr_err", 32'(e), 32'h1);
      chk("w0_fault_wr_count", wrc[0], 32'd2);
      chk("w0_fault_rd_count", rdc[0], 32'd2);
      xfer(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, s, rv, e);
      chk("w0_mem_kept", rv, 32'hDE22BE44);
      xfer(0, 1'b0, 1'b1, 32'h1FFC, 32'hA5C3_5A3C, 4'hF, s, rv, e);
      chk("w0_top_wr_err", 32'(e), 32'h0);
      xfer(0, 1'b1, 1'b0, 32'h1FFC, 32'h0, 4'h0, s, rv, e);
      chk("w0_top_rd_data", rv, 32'hA5C3_5A3C);
      xfer(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, s, rv, e);
      chk("w0_zero_init", rv, 32'h0);

      // Three-wait instance.
      xfer(1, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, s, rv, e);
      chk("w3_wr_stall", 32'(s), 32'd3);
      xfer(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, s, rv, e);
      chk("w3_rd_stall", 32'(s), 32'd3);
      chk("w3_rd_data", rv, 32'hCAFEF00D);
      chk("w3_rd_err", 32'(e), 32'h0);
      // Master withdraws during the stall.
      @(negedge clk); rd[1] = 1'b1; addr[1] = 32'h20; #1;
      chk("w3_drop_wreq_hi", 32'(wreq[1]), 32'h1);
      @(posedge clk); #1; rd[1] = 1'b0; #1;
      chk("w3_drop_wreq_lo", 32'(wreq[1]), 32'h0);
      @(posedge clk); #1;
      chk("w3_drop_err", 32'(err[1]), 32'h0);
      chk("w3_drop_rd_count", rdc[1], 32'd1);
      xfer(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, s, rv, e);
      chk("w3_after_drop_stall", 32'(s), 32'd3);
      // Reset during the second stall cycle of a write.
      @(negedge clk);
      wr[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'h12345678; be[1] = 4'hF;
      @(posedge clk); #1;
      rst[1] = 1'b1; #1;
      chk("w3_rst_wreq", 32'(wreq[1]), 32'h1);
      @(posedge clk); #1;
      wr[1] = 1'b0; rst[1] = 1'b0;
      chk("w3_rst_wr_count", wrc[1], 32'd0);
      chk("w3_rst_rd_count", rdc[1], 32'd0);
      xfer(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, s, rv, e);
      chk("w3_rst_stall", 32'(s), 32'd3);
      chk("w3_rst_mem_kept", rv, 32'hCAFEF00D);
      chk("w3_rst_wr_count_after", wrc[1], 32'd0);

      // Random-wait instance: range, coverage and repeatability.
      run_rand(0);
      chk("rnd_rd_count", rdc[2], 32'(NRD));
      run_rand(1);
      mx = 0; mism = 0;
      for (int v = 0; v < 4; v++) hist[v] = 0;
      for (int i = 0; i < NRD; i++) begin
         if (seq_a[i] > mx) mx = seq_a[i];
         if (seq_a[i] >= 0 && seq_a[i] < 4) hist[seq_a[i]]++;
         if (seq_a[i] != seq_b[i]) mism++;
      end
      chk("rnd_max_le3", 32'(mx <= 3), 32'h1);
      for (int v = 0; v < 4; v++)
         chk($sformatf("rnd_hist%0d_seen", v), 32'(hist[v] > 0), 32'h1);
      chk("rnd_repeat", 32'(mism), 32'd0);
      chk("no_timeouts", 32'(timeouts), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
